// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage SRAM controller: splits each 32-bit load/store into two 16-bit SRAM phases.
// Optional macro SRAM_OOR_GUARD_EN rejects out-of-range addresses with a one-cycle err.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wd_q, wd_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               oor_q, oor_d;
  logic [31:0]        off;
  logic               req;
  logic               oor_req;

  assign off = address - BASE_ADDR;
  assign req = rd_en | wr_en;

`ifdef SRAM_OOR_GUARD_EN
  assign oor_req = (address < BASE_ADDR) || ((off >> (SRAM_AW + 1)) != 32'd0);
`else
  assign oor_req = 1'b0;
`endif

  assign read_data = rdata_q;
  assign err       = (state_q == DONE) && oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    word_d      = word_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    oor_d       = oor_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;

    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          // Write wins when both enables are high.
          wr_d   = wr_en;
          word_d = off[SRAM_AW:2];
          wd_d   = write_data;
          cnt_d  = '0;
          oor_d  = oor_req;
          if (oor_req) begin
            state_d = DONE;
            if (!wr_en) rdata_d = '0;
          end else begin
            state_d = LOW;
          end
        end
      end

      LOW: begin
        sram_addr = {word_q, 1'b0};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wd_q[15:0];
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = HIGH;
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wd_q[31:16];
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl: SRAM pad model plus a word-level reference memory.
// Honours SRAM_OOR_GUARD_EN when the macro is defined for the build.
module tb_mem_stage_sram_ctrl;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int W = 2;
  localparam int AW = 18;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        err;
  logic [AW-1:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(W),
    .SRAM_AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .err        (err),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  function automatic logic [15:0] initPattern(input int i);
    logic [31:0] t;
    t = 32'(i) * 32'd40503 + 32'd12345;
    return t[15:0];
  endfunction

  // SRAM pad model: combinational read, write latched on the clock edge.
  logic [15:0] sramMem [0:1023];
  assign sram_dq_in = sramMem[sram_addr[9:0]];

  initial begin
    for (int i = 0; i < 1024; i++) sramMem[i] = initPattern(i);
    forever begin
      @(posedge clk);
      if (sram_we_n === 1'b0) sramMem[sram_addr[9:0]] = sram_dq_out;
    end
  end

  // Reference: whole 32-bit words, plus the last value a read returned.
  logic [31:0] refMem [0:511];
  logic [31:0] expRd;

  logic        obsReady [40];
  logic [AW-1:0] obsAddr [40];
  logic        obsWe [40];
  logic        obsOe [40];
  logic        obsErr [40];
  logic [15:0] obsDq [40];
  logic [31:0] obsRd [40];
  int          nObs;
  bit          timedOut;

  // Drives one request and records every cycle up to and including the first ready=1.
  task automatic run_access(input bit doRd, input bit doWr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    bit doneSeen;
    address    = addr;
    write_data = wdata;
    rd_en      = doRd;
    wr_en      = doWr;
    nObs       = 0;
    doneSeen   = 0;
    for (int k = 0; k < 40 && !doneSeen; k++) begin
      @(negedge clk);
      obsReady[k] = ready;
      obsAddr[k]  = sram_addr;
      obsWe[k]    = sram_we_n;
      obsOe[k]    = sram_dq_oe;
      obsErr[k]   = err;
      obsDq[k]    = sram_dq_out;
      obsRd[k]    = read_data;
      nObs        = k + 1;
      if (ready === 1'b1) doneSeen = 1;
    end
    timedOut = !doneSeen;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++; if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    compared++; if (sram_we_n !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_we_n: got %b expected 1", sram_we_n); end
    compared++; if (sram_dq_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_oe: got %b expected 0", sram_dq_oe); end
    compared++; if (read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_read_data: got %h expected 0", read_data); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    compared++; if (sram_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0", sram_addr); end
    compared++; if (sram_dq_out !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_dq_out: got %h expected 0", sram_dq_out); end
    @(posedge clk);
    #1;
    expRd = '0;
  endtask

  task automatic test_write_basic;
    run_access(1'b0, 1'b1, BASE, 32'hDEADBEEF);
    refMem[0] = 32'hDEADBEEF;
    compared++; if (timedOut || nObs != 2 * W + 2) begin mismatched++; $display("[TB] FAIL wr_stall_len: got %0d cycles expected %0d", nObs - 1, 2 * W + 1); end
    compared++; if (obsWe[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_idle_we_n: got %b expected 1", obsWe[0]); end
    for (int k = 1; k <= 2 * W; k++) begin
      logic [AW-1:0] ea;
      logic [15:0] ed;
      ea = (k <= W) ? AW'(0) : AW'(1);
      ed = (k <= W) ? 16'hBEEF : 16'hDEAD;
      compared++; if (obsAddr[k] !== ea) begin mismatched++; $display("[TB] FAIL wr_addr[%0d]: got %h expected %h", k, obsAddr[k], ea); end
      compared++; if (obsDq[k] !== ed) begin mismatched++; $display("[TB] FAIL wr_dq[%0d]: got %h expected %h", k, obsDq[k], ed); end
      compared++; if (obsWe[k] !== 1'b0 || obsOe[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_strobe[%0d]: got we_n=%b oe=%b expected 0/1", k, obsWe[k], obsOe[k]); end
    end
    compared++; if (obsWe[nObs-1] !== 1'b1 || obsOe[nObs-1] !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_done_strobe: got we_n=%b oe=%b expected 1/0", obsWe[nObs-1], obsOe[nObs-1]); end
    compared++; if (obsRd[nObs-1] !== expRd) begin mismatched++; $display("[TB] FAIL wr_read_data: got %h expected %h", obsRd[nObs-1], expRd); end
  endtask

  task automatic test_read_basic;
    bit oeSeen, weSeen;
    run_access(1'b1, 1'b0, BASE, 32'h0);
    expRd = 32'hDEADBEEF;
    oeSeen = 0; weSeen = 0;
    for (int k = 0; k < nObs; k++) begin
      if (obsOe[k] !== 1'b0) oeSeen = 1;
      if (obsWe[k] !== 1'b1) weSeen = 1;
    end
    compared++; if (timedOut || nObs != 2 * W + 2) begin mismatched++; $display("[TB] FAIL rd_stall_len: got %0d cycles expected %0d", nObs - 1, 2 * W + 1); end
    compared++; if (obsRd[nObs-1] !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL rd_data: got %h expected deadbeef", obsRd[nObs-1]); end
    compared++; if (oeSeen || weSeen) begin mismatched++; $display("[TB] FAIL rd_strobes: got oe_seen=%b we_seen=%b expected 0/0", oeSeen, weSeen); end
    compared++; if (obsErr[nObs-1] !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_err: got %b expected 0", obsErr[nObs-1]); end
  endtask

  task automatic test_both_enables;
    logic [31:0] wd;
    wd = $urandom;
    run_access(1'b1, 1'b1, BASE + 32'd8, wd);
    refMem[2] = wd;
    compared++; if (timedOut || nObs != 2 * W + 2) begin mismatched++; $display("[TB] FAIL both_stall_len: got %0d cycles expected %0d", nObs - 1, 2 * W + 1); end
    compared++; if (obsAddr[1] !== AW'(4) || obsAddr[2 * W] !== AW'(5)) begin mismatched++; $display("[TB] FAIL both_addr: got %h/%h expected 4/5", obsAddr[1], obsAddr[2 * W]); end
    compared++; if (obsWe[1] !== 1'b0 || obsDq[2 * W] !== wd[31:16]) begin mismatched++; $display("[TB] FAIL both_write: got we_n=%b dq=%h expected 0/%h", obsWe[1], obsDq[2 * W], wd[31:16]); end
    compared++; if (obsRd[nObs-1] !== expRd) begin mismatched++; $display("[TB] FAIL both_read_data: got %h expected %h", obsRd[nObs-1], expRd); end
  endtask

  task automatic test_back_to_back;
    int len1;
    logic doneReady1;
    logic [31:0] rd1;
    run_access(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    len1 = timedOut ? 0 : nObs - 1;
    doneReady1 = obsReady[nObs-1];
    rd1 = obsRd[nObs-1];
    run_access(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    compared++; if (len1 != 2 * W + 1) begin mismatched++; $display("[TB] FAIL b2b_len1: got %0d expected %0d", len1, 2 * W + 1); end
    compared++; if (rd1 !== refMem[1]) begin mismatched++; $display("[TB] FAIL b2b_data1: got %h expected %h", rd1, refMem[1]); end
    compared++; if (doneReady1 !== 1'b1 || obsReady[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_gap: got done=%b next=%b expected 1/0", doneReady1, obsReady[0]); end
    compared++; if (timedOut || nObs != 2 * W + 2) begin mismatched++; $display("[TB] FAIL b2b_len2: got %0d expected %0d", nObs - 1, 2 * W + 1); end
    compared++; if (obsRd[nObs-1] !== refMem[3]) begin mismatched++; $display("[TB] FAIL b2b_data2: got %h expected %h", obsRd[nObs-1], refMem[3]); end
    expRd = refMem[3];
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      int op, word;
      bit isWr;
      logic [31:0] addr, wd, er;
      op   = int'($urandom_range(0, 2));
      word = int'($urandom_range(0, 255));
      wd   = $urandom;
      addr = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
`ifndef SRAM_OOR_GUARD_EN
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h0008_0000;
`endif
      isWr = (op != 0);
      run_access(op != 1, op != 0, addr, wd);
      compared++; if (timedOut || nObs != 2 * W + 2) begin mismatched++; $display("[TB] FAIL rnd_len[%0d]: got %0d expected %0d", it, nObs - 1, 2 * W + 1); end
      for (int k = 1; k <= 2 * W && k < nObs; k++) begin
        logic [AW-1:0] ea;
        ea = AW'(word * 2 + ((k > W) ? 1 : 0));
        compared++; if (obsAddr[k] !== ea || obsWe[k] !== !isWr || obsOe[k] !== isWr) begin mismatched++; $display("[TB] FAIL rnd_bus[%0d.%0d]: got addr=%h we_n=%b oe=%b expected %h/%b/%b", it, k, obsAddr[k], obsWe[k], obsOe[k], ea, !isWr, isWr); end
        if (isWr) begin
          compared++; if (obsDq[k] !== ((k > W) ? wd[31:16] : wd[15:0])) begin mismatched++; $display("[TB] FAIL rnd_dq[%0d.%0d]: got %h expected %h", it, k, obsDq[k], (k > W) ? wd[31:16] : wd[15:0]); end
        end
      end
      if (isWr) refMem[word] = wd;
      else      expRd = refMem[word];
      er = expRd;
      compared++; if (obsRd[nObs-1] !== er || obsErr[nObs-1] !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd_done[%0d]: got data=%h err=%b expected %h/0", it, obsRd[nObs-1], obsErr[nObs-1], er); end
    end
  endtask

`ifdef SRAM_OOR_GUARD_EN
  task automatic test_oor;
    bit weSeen;
    run_access(1'b1, 1'b0, 32'd512, 32'h0);
    weSeen = 0;
    for (int k = 0; k < nObs; k++) if (obsWe[k] !== 1'b1) weSeen = 1;
    compared++; if (timedOut || nObs != 2) begin mismatched++; $display("[TB] FAIL oor_rd_len: got %0d expected 1", nObs - 1); end
    compared++; if (obsErr[nObs-1] !== 1'b1 || obsRd[nObs-1] !== 32'h0) begin mismatched++; $display("[TB] FAIL oor_rd_done: got err=%b data=%h expected 1/0", obsErr[nObs-1], obsRd[nObs-1]); end
    compared++; if (weSeen) begin mismatched++; $display("[TB] FAIL oor_rd_we: got a we_n pulse expected none"); end
    @(negedge clk);
    compared++; if (err !== 1'b0 || ready !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_err_clear: got err=%b ready=%b expected 0/1", err, ready); end
    @(posedge clk);
    #1;
    expRd = 32'h0;
    run_access(1'b0, 1'b1, BASE + 32'h0008_0000, 32'h12345678);
    weSeen = 0;
    for (int k = 0; k < nObs; k++) if (obsWe[k] !== 1'b1 || obsOe[k] !== 1'b0) weSeen = 1;
    compared++; if (timedOut || nObs != 2 || obsErr[nObs-1] !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_wr: got len=%0d err=%b expected 1/1", nObs - 1, obsErr[nObs-1]); end
    compared++; if (weSeen || obsRd[nObs-1] !== expRd) begin mismatched++; $display("[TB] FAIL oor_wr_side: got strobe=%b data=%h expected 0/%h", weSeen, obsRd[nObs-1], expRd); end
  endtask
`endif

  task automatic test_reset_mid_write;
    address = BASE + 32'd40; write_data = 32'hA5A5_5A5A; wr_en = 1'b1; rd_en = 1'b0;
    for (int k = 0; k <= W + 1; k++) @(negedge clk);
    compared++; if (sram_addr !== AW'(21) || sram_we_n !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_in_high: got addr=%h we_n=%b expected 15/0", sram_addr, sram_we_n); end
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_idle: got ready=%b we_n=%b oe=%b expected 1/1/0", ready, sram_we_n, sram_dq_oe); end
    compared++; if (sram_addr !== '0 || read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_regs: got addr=%h data=%h expected 0/0", sram_addr, read_data); end
    @(negedge clk);
    compared++; if (ready !== 1'b1 || sram_we_n !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_abandon: got ready=%b we_n=%b expected 1/1", ready, sram_we_n); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    for (int i = 0; i < 512; i++) refMem[i] = {initPattern(2 * i + 1), initPattern(2 * i)};
    test_reset();
    test_write_basic();
    test_read_basic();
    test_both_enables();
    test_back_to_back();
    test_random();
`ifdef SRAM_OOR_GUARD_EN
    test_oor();
`endif
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
